// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered, time-multiplexed N-digit hex seven-segment driver.
//
// A producer hands over a result word (hex nibbles + overflow flag) through a
// valid/ready handshake into a pending buffer. The pending word moves into the
// display register only at a frame wrap, so one frame never mixes old and new digits.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active high
//   data_in     DIGITS hex nibbles, nibble k drives digit k (digit 0 rightmost)
//   ovf_in      overflow flag captured with data_in (shows dashes on all digits)
//   data_valid  producer offers a word
//   data_ready  pending buffer is empty, a word can be accepted
//   seg_out     segments {g,f,e,d,c,b,a}
//   an          digit enables, bit k = digit k
//   frame_tick  one-cycle pulse as digit 0 is newly selected
//
// Optional build macro SEG_SCAN_BLANK_LZ_EN: leading-zero blanking. Digit k>0 is
// dark when nibbles k..DIGITS-1 are all zero; digit 0 is never blanked and the
// overflow dashes override blanking.

module seg_scan_hex (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  // Active-high segment code, bit0 = a
  always_comb begin
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic                ovf_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic [6:0]          seg_out,
  output logic [DIGITS-1:0]   an,
  output logic                frame_tick
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef struct packed {
    logic                ovf;
    logic [4*DIGITS-1:0] data;
  } word_t;

  logic [PW-1:0] presc;
  logic [DW-1:0] dig_idx;
  word_t         pend_q, disp_q;
  logic          pend_full;
  logic          step, wrap;

  assign step = (presc == PW'(REFRESH_DIV - 1));
  assign wrap = step && (dig_idx == DW'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      dig_idx    <= '0;
      pend_q     <= '0;
      pend_full  <= 1'b0;
      disp_q     <= '0;
      frame_tick <= 1'b0;
    end else begin
      presc      <= step ? '0 : presc + PW'(1);
      frame_tick <= wrap;
      if (step)
        dig_idx <= wrap ? '0 : dig_idx + DW'(1);
      // Capture needs an empty buffer and swap needs a full one, so the two
      // branches are mutually exclusive in any cycle.
      if (data_valid && !pend_full) begin
        pend_q    <= '{ovf: ovf_in, data: data_in};
        pend_full <= 1'b1;
      end else if (wrap && pend_full) begin
        disp_q    <= pend_q;
        pend_full <= 1'b0;
      end
    end
  end

  assign data_ready = ~pend_full;

  // Per-digit decode and blanking, then select the active digit.
  logic [DIGITS-1:0][6:0] dig_seg;
  logic [DIGITS-1:0]      blank;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    seg_scan_hex u_hex (
      .nib (disp_q.data[4*k +: 4]),
      .seg (dig_seg[k])
    );
`ifdef SEG_SCAN_BLANK_LZ_EN
    if (k == 0) begin : g_keep
      assign blank[k] = 1'b0;
    end else begin : g_lz
      assign blank[k] = ~disp_q.ovf & ~|disp_q.data[4*DIGITS-1:4*k];
    end
`else
    assign blank[k] = 1'b0;
`endif
  end

  logic [6:0]        seg_hi;
  logic [DIGITS-1:0] an_hi;

  always_comb begin
    seg_hi = 7'h00;
    an_hi  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_idx == DW'(k)) begin
        an_hi[k] = ~blank[k];
        seg_hi   = blank[k] ? 7'h00 : (disp_q.ovf ? 7'h40 : dig_seg[k]);
      end
    end
  end

  assign seg_out = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
  assign an      = (ACTIVE_LOW != 0) ? ~an_hi  : an_hi;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised, double-buffered, time-multiplexed seven-segment display driver for an N-digit hex display; it succeeds the fixed 4-digit multiplexer and hex decoder pair.
- Accepts a result word (typically ALU output plus overflow) through a valid/ready handshake.
- Swaps new data in only at frame boundaries, so a frame never shows a mix of old and new digits.
- Decodes internally and drives the segment and anode lines directly.

Parameters:
- DIGITS, 4: number of display digits (1..8).
- REFRESH_DIV, 50000: clk cycles each digit stays enabled (>=1).
- ACTIVE_LOW, 1: 1 = seg_out and an are active-low; 0 = active-high.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  4*DIGITS  hex nibbles; nibble k = data_in[4k+3:4k] is shown on digit k (digit 0 is rightmost).
- ovf_in  input  1  overflow flag captured with data_in.
- data_valid  input  1  producer offers data_in/ovf_in.
- data_ready  output  1  block can accept a word.
- seg_out  output  7  segments {g,f,e,d,c,b,a}, bit0 = a.
- an  output  DIGITS  digit enables; bit k selects digit k.
- frame_tick  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- State registers:
  - presc: prescaler, counts 0..REFRESH_DIV-1.
  - dig_idx: current digit, 0..DIGITS-1.
  - pend_data/pend_ovf/pend_full: pending buffer.
  - disp_data/disp_ovf: display register.
- Reset (rst=1 at a clock edge): presc=0, dig_idx=0, pend_full=0, disp_data=0, disp_ovf=0. Reset mid-operation discards any pending word.
- Output reset values, active-low, DIGITS=4:
  - an = 4'b1110.
  - seg_out = 7'h40 (digit '0').
  - data_ready = 1.
  - frame_tick = 0.
- Prescaler and digit index:
  - presc increments each cycle; at REFRESH_DIV-1 it wraps to 0 and is a "step" cycle.
  - On a step, dig_idx increments.
  - When dig_idx = DIGITS-1 on a step, dig_idx wraps to 0 and that cycle is a "frame wrap".
  - REFRESH_DIV=1: every cycle is a step.
- frame_tick is registered: it is high for exactly the one cycle after a frame wrap edge, i.e. coincident with dig_idx=0 being newly selected. Frame period = DIGITS*REFRESH_DIV cycles.
- Handshake:
  - data_ready = !pend_full, driven from a register, never combinational on data_valid.
  - Transfer occurs when data_valid && data_ready at a clock edge: data_in/ovf_in are captured into the pending buffer and pend_full is set.
  - data_in is ignored when data_ready=0; the producer must hold data_valid.
- Buffer swap:
  - On a frame-wrap edge with pend_full=1: disp <- pend and pend_full clears. The new data is visible from the first cycle of the next frame.
  - Capture and swap cannot conflict, since capture needs pend_full=0 and swap needs pend_full=1.
  - Words offered back-to-back are accepted at most one per frame.
- Decode: combinational from registered dig_idx and disp_*, with zero added latency.
  - Active-high hex codes:
    - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
    - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - disp_ovf=1: every digit shows dash 40, overriding the nibble.
  - an: only bit dig_idx is asserted.
  - ACTIVE_LOW=1 inverts both seg_out and an at the outputs.
- Width rules: presc width is clog2(REFRESH_DIV), minimum 1; dig_idx width is clog2(DIGITS), minimum 1.

Optional Feature:
- Macro: SEG_SCAN_BLANK_LZ_EN.
- Defined:
  - Leading-zero blanking: digit k (k>0) is blanked when disp_data nibbles k..DIGITS-1 are all zero.
  - A blanked digit has seg_out off and its an bit deasserted.
  - Digit 0 is never blanked, so value 0 shows '0'.
  - Overflow dashes override blanking, so all digits show '-'.
- Undefined: all digits are always displayed, including leading zeros.
- Handshake and timing are identical in both builds.

Test Plan (bench uses DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1):
- Reset then run 32 cycles:
  - an sequence is 1110 to 1101 to 1011 to 0111, 4 cycles each, repeating.
  - frame_tick pulses every 16 cycles.
  - seg_out = 7'h40 throughout.
- Offer data_in=16'h12AF, data_valid=1, mid-frame:
  - data_ready drops the cycle after acceptance.
  - Display stays 0000 until the frame wrap, then shows digit0=71, digit1=77, digit2=5B, digit3=06 (all inverted).
  - data_ready returns to 1 at the frame wrap.
- Hold data_valid=1 with new values every cycle for 3 frames: exactly one word is accepted per frame, and no frame shows mixed old/new nibbles.
- Offer ovf_in=1 with data_in=16'h0003: after the wrap, all four digits show seg_out=~7'h40=7'h3F.
- Assert rst for 1 cycle while pend_full=1, mid-frame:
  - Next cycle: pend_full=0, data_ready=1, an=1110, seg_out=7'h40.
  - The pending word is never displayed.
- SEG_SCAN_BLANK_LZ_EN defined, data_in=16'h0050:
  - Digits 3 and 2 are blanked with an deasserted.
  - Digit 1 shows '5' and digit 0 shows '0'.
  - With data_in=16'h0000, only digit 0 is lit and shows '0'.
